// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute slice: opcodes, funct codes, ALUOp and
// ALU operation codes, plus the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu_core.sv
// Purely combinational 32-bit ALU: A, B, shamt and a 4-bit operation code in,
// result out. Unrecognised operation codes yield zero.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        shamt_i,
  input  logic [3:0]        alu_ctrl_i,
  output logic [DATA_W-1:0] result_o
);

  logic slt_s;

  assign slt_s = ($signed(a_i) < $signed(b_i));

  // Operation select; add/sub wrap naturally at DATA_W bits.
  always_comb begin
    result_o = {DATA_W{1'b0}};
    case (alu_ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, slt_s};
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_SLL: result_o = b_i << shamt_i;
      ALU_SRL: result_o = b_i >> shamt_i;
      default: result_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// ID-stage control decode, ALU-operation decode and the EX-stage ALU with a
// single register stage feeding the EX/MEM boundary.
module mips_exec_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic [1:0]        alu_op,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [4:0]        write_reg
);

  ctrl_t             ctrl_s;
  logic [3:0]        alu_ctrl_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] result_s;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic              zero_d, zero_q;
  logic [4:0]        write_reg_d, write_reg_q;
  logic              unused_rs_field_s;

  // The rs index is consumed by the register file, not here.
  assign unused_rs_field_s = ^instr[25:21];

  // Main control; concatenation order matches ctrl_t field order.
  always_comb begin
    ctrl_s = '0;
    case (instr[31:26])
      OP_RTYPE: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
      OP_LW:    ctrl_s = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OP_SW:    ctrl_s = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
      OP_BEQ:   ctrl_s = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB};
      OP_ADDI:  ctrl_s = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
      default:  ctrl_s = '0;
    endcase
  end

  // ALU operation decode from ALUOp and funct.
  always_comb begin
    alu_ctrl_s = ALU_NONE;
    case (ctrl_s.alu_op)
      ALUOP_ADD, ALUOP_RSVD: alu_ctrl_s = ALU_ADD;
      ALUOP_SUB:             alu_ctrl_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (instr[5:0])
          FN_ADD:  alu_ctrl_s = ALU_ADD;
          FN_SUB:  alu_ctrl_s = ALU_SUB;
          FN_AND:  alu_ctrl_s = ALU_AND;
          FN_OR:   alu_ctrl_s = ALU_OR;
          FN_NOR:  alu_ctrl_s = ALU_NOR;
          FN_SLT:  alu_ctrl_s = ALU_SLT;
          FN_SLL:  alu_ctrl_s = ALU_SLL;
          FN_SRL:  alu_ctrl_s = ALU_SRL;
          default: alu_ctrl_s = ALU_NONE;
        endcase
      end
      default: alu_ctrl_s = ALU_NONE;
    endcase
  end

  assign op_b_s = ctrl_s.alu_src ? sign_ext16(instr[15:0]) : rt_data;

  mips_alu_core #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a_i       (rs_data),
    .b_i       (op_b_s),
    .shamt_i   (instr[10:6]),
    .alu_ctrl_i(alu_ctrl_s),
    .result_o  (result_s)
  );

  // Next-state for the EX/MEM register.
  always_comb begin
    alu_result_d = result_s;
    zero_d       = (result_s == {DATA_W{1'b0}});
    if (ctrl_s.reg_dst) begin
      write_reg_d = instr[15:11];
    end else begin
      write_reg_d = instr[20:16];
    end
  end

  // EX/MEM register; reset wins over the in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= {DATA_W{1'b0}};
      zero_q       <= 1'b0;
      write_reg_q  <= 5'd0;
    end else begin
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign reg_dst    = ctrl_s.reg_dst;
  assign alu_src    = ctrl_s.alu_src;
  assign mem_to_reg = ctrl_s.mem_to_reg;
  assign reg_write  = ctrl_s.reg_write;
  assign mem_read   = ctrl_s.mem_read;
  assign mem_write  = ctrl_s.mem_write;
  assign branch     = ctrl_s.branch;
  assign alu_op     = ctrl_s.alu_op;
  assign alu_ctrl   = alu_ctrl_s;
  assign alu_result = alu_result_q;
  assign zero       = zero_q;
  assign write_reg  = write_reg_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: instruction-level reference model checked every
// cycle, plus hand-computed literal expectations for the directed vectors.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  write_reg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_res;
  logic        exp_zero;
  logic [4:0]  exp_wr;
  logic        exp_valid = 1'b0;

  always #5 clk = ~clk;

  mips_exec_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .reg_dst   (reg_dst),
    .alu_src   (alu_src),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .alu_op    (alu_op),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .zero      (zero),
    .write_reg (write_reg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level semantics: what each instruction computes in EX.
  function automatic logic [31:0] model_result(input logic [31:0] ins, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [5:0]  op;
    logic [31:0] imm;
    logic [4:0]  sh;
    op  = ins[31:26];
    imm = {{16{ins[15]}}, ins[15:0]};
    sh  = ins[10:6];
    if (op == 6'h23 || op == 6'h2B || op == 6'h08) return a + imm;
    if (op == 6'h04) return a - b;
    if (op != 6'h00) return a + b;
    case (ins[5:0])
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h27:   return ~(a | b);
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00:   return b << sh;
      6'h02:   return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
  function automatic logic [8:0] model_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_0_0_1_0_0_0_10;
      6'h23:   return 9'b0_1_1_1_1_0_0_00;
      6'h2B:   return 9'b0_1_0_0_0_1_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_1_0_0_0_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_alu_ctrl(input logic [31:0] ins);
    if (ins[31:26] == 6'h04) return 4'b0110;
    if (ins[31:26] != 6'h00) return 4'b0010;
    case (ins[5:0])
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h27:   return 4'b1100;
      6'h2A:   return 4'b0111;
      6'h00:   return 4'b1000;
      6'h02:   return 4'b1001;
      default: return 4'b1111;
    endcase
  endfunction

  // Reference register stage.
  always @(posedge clk) begin
    if (rst) begin
      exp_res  <= 32'd0;
      exp_zero <= 1'b0;
      exp_wr   <= 5'd0;
    end else begin
      exp_res  <= model_result(instr, rs_data, rt_data);
      exp_zero <= (model_result(instr, rs_data, rt_data) == 32'd0);
      exp_wr   <= (instr[31:26] == 6'h00) ? instr[15:11] : instr[20:16];
    end
    exp_valid <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("ctrl", {23'd0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op},
          {23'd0, model_ctrl(instr[31:26])});
    check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, model_alu_ctrl(instr)});
    if (exp_valid) begin
      check("alu_result", alu_result, exp_res);
      check("zero", {31'd0, zero}, {31'd0, exp_zero});
      check("write_reg", {27'd0, write_reg}, {27'd0, exp_wr});
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(posedge clk);
    #2;
    instr   = ins;
    rs_data = a;
    rt_data = b;
    rst     = r;
    #1;
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    instr   = 32'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    drive(32'd0, 32'd0, 32'd0, 1'b1);
    drive(32'h00221820, 32'd5, 32'd7, 1'b1);
    settle();
    check("lit_rst_result", alu_result, 32'd0);
    check("lit_rst_zero", {31'd0, zero}, 32'd0);
    check("lit_rst_wr", {27'd0, write_reg}, 32'd0);

    // add $3,$1,$2 (reset still sampled at the first edge here)
    drive(32'h00221820, 32'd5, 32'd7, 1'b0);
    check("lit_add_regdst", {31'd0, reg_dst}, 32'd1);
    check("lit_add_regwrite", {31'd0, reg_write}, 32'd1);
    check("lit_add_aluctrl", {28'd0, alu_ctrl}, 32'h2);
    settle();
    check("lit_add_result", alu_result, 32'd12);
    check("lit_add_zero", {31'd0, zero}, 32'd0);
    check("lit_add_wr", {27'd0, write_reg}, 32'd3);

    // lw $2,-4($1)
    drive(32'h8C22FFFC, 32'h100, 32'h55, 1'b0);
    check("lit_lw_ctrl", {29'd0, alu_src, mem_read, mem_to_reg}, 32'h7);
    settle();
    check("lit_lw_result", alu_result, 32'hFC);
    check("lit_lw_wr", {27'd0, write_reg}, 32'd2);

    // beq equal
    drive(32'h10220003, 32'd9, 32'd9, 1'b0);
    check("lit_beq_branch", {31'd0, branch}, 32'd1);
    check("lit_beq_aluop", {30'd0, alu_op}, 32'h1);
    check("lit_beq_aluctrl", {28'd0, alu_ctrl}, 32'h6);
    settle();
    check("lit_beq_result", alu_result, 32'd0);
    check("lit_beq_zero", {31'd0, zero}, 32'd1);

    drive(32'h0022182A, 32'hFFFFFFFF, 32'd1, 1'b0);
    settle();
    check("lit_slt_result", alu_result, 32'd1);

    drive(32'h00221820, 32'h7FFFFFFF, 32'd1, 1'b0);
    settle();
    check("lit_wrap_result", alu_result, 32'h80000000);
    check("lit_wrap_zero", {31'd0, zero}, 32'd0);

    drive(32'h00021900, 32'd0, 32'd1, 1'b0);
    settle();
    check("lit_sll_result", alu_result, 32'h10);

    drive(32'h00021902, 32'd0, 32'h80000000, 1'b0);
    settle();
    check("lit_srl_result", alu_result, 32'h08000000);

    drive(32'h00021800, 32'd0, 32'hDEADBEEF, 1'b0);
    settle();
    check("lit_sll0_result", alu_result, 32'hDEADBEEF);

    // unknown opcode: no control asserted, ALU defaults to add of rs+rt
    drive(32'hFC430000, 32'd3, 32'd4, 1'b0);
    check("lit_unk_ctrl", {23'd0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                           branch, alu_op}, 32'd0);
    settle();
    check("lit_unk_result", alu_result, 32'd7);
    check("lit_unk_wr", {27'd0, write_reg}, 32'd3);

    drive(32'h0022183F, 32'd5, 32'd7, 1'b0);
    check("lit_badfn_aluctrl", {28'd0, alu_ctrl}, 32'hF);
    settle();
    check("lit_badfn_result", alu_result, 32'd0);
    check("lit_badfn_zero", {31'd0, zero}, 32'd1);

    drive(32'hAC220008, 32'h40, 32'd1, 1'b0);
    check("lit_sw_memwrite", {31'd0, mem_write}, 32'd1);
    check("lit_sw_regwrite", {31'd0, reg_write}, 32'd0);
    settle();
    check("lit_sw_result", alu_result, 32'h48);

    drive(32'h2022FFFF, 32'd0, 32'd9, 1'b0);
    settle();
    check("lit_addi_result", alu_result, 32'hFFFFFFFF);

    drive(32'h00221824, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    settle();
    check("lit_and_result", alu_result, 32'hF000F000);
    drive(32'h00221825, 32'hF0F0F0F0, 32'h0F000000, 1'b0);
    settle();
    check("lit_or_result", alu_result, 32'hFFF0F0F0);
    drive(32'h00221827, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
    settle();
    check("lit_nor_result", alu_result, 32'd0);
    drive(32'h00221822, 32'd3, 32'd5, 1'b0);
    settle();
    check("lit_sub_result", alu_result, 32'hFFFFFFFE);

    // reset in the middle of a valid add, then release
    drive(32'h00221820, 32'd20, 32'd22, 1'b1);
    settle();
    check("lit_midrst_result", alu_result, 32'd0);
    check("lit_midrst_zero", {31'd0, zero}, 32'd0);
    check("lit_midrst_wr", {27'd0, write_reg}, 32'd0);
    drive(32'h00221820, 32'd20, 32'd22, 1'b0);
    settle();
    check("lit_release_result", alu_result, 32'd42);
    check("lit_release_wr", {27'd0, write_reg}, 32'd3);

    settle();
    settle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
